// File: rtl/sync_box_pkg.sv
// Shared encodings for the dual-core SyncBox: atomic instruction types,
// arbiter FSM states and the debug owner code.
package sync_box_pkg;

    typedef enum logic [1:0] {
        INSTR_NONE    = 2'b00,
        INSTR_RESERVE = 2'b01,
        INSTR_COND    = 2'b10,
        INSTR_RSVD    = 2'b11
    } instr_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_GRANT_P0 = 2'b01,
        ST_GRANT_P1 = 2'b10
    } state_e;

    localparam logic [1:0] OWNER_IDLE = 2'b00;
    localparam logic [1:0] OWNER_P0   = 2'b01;
    localparam logic [1:0] OWNER_P1   = 2'b10;

endpackage

// File: rtl/sync_rsv_unit.sv
// Per-core reservation tracker: holds the reserved address, watches the peer
// core's completed writes for a kill, and registers the trigger result.
module sync_rsv_unit
    import sync_box_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger_i,
    input  logic [1:0]  instr_type_i,
    input  logic [31:0] addr_i,
    input  logic        peer_complete_i,
    input  logic        peer_write_i,
    input  logic [31:0] peer_addr_i,
    input  logic        clear_i,
    input  logic        lose_i,
    output logic        cond_hit_o,
    output logic        success_o
);

    logic              rsv_v_q, rsv_v_d;
    logic [ADDR_W-1:0] rsv_a_q, rsv_a_d;
    logic              success_q, success_d;
    logic              kill;
    instr_e            instr;

    assign instr = instr_e'(instr_type_i);

    // A peer write landing on our address kills the reservation this cycle,
    // so a CONDITIONAL issued in the same cycle already sees it gone.
    assign kill = peer_complete_i && peer_write_i && rsv_v_q
                  && (peer_addr_i[ADDR_W-1:0] == rsv_a_q);

    assign cond_hit_o = trigger_i && (instr == INSTR_COND) && rsv_v_q
                        && (addr_i[ADDR_W-1:0] == rsv_a_q) && !kill;

    always_comb begin
        rsv_v_d   = rsv_v_q;
        rsv_a_d   = rsv_a_q;
        success_d = success_q;
        if (kill || clear_i) rsv_v_d = 1'b0;
        if (trigger_i) begin
            unique case (instr)
                INSTR_RESERVE: begin
                    rsv_v_d   = 1'b1;
                    rsv_a_d   = addr_i[ADDR_W-1:0];
                    success_d = 1'b1;
                end
                INSTR_COND: begin
                    rsv_v_d   = 1'b0;
                    success_d = cond_hit_o && !lose_i;
                end
                default: success_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsv_v_q   <= 1'b0;
            rsv_a_q   <= '0;
            success_q <= 1'b0;
        end else begin
            rsv_v_q   <= rsv_v_d;
            rsv_a_q   <= rsv_a_d;
            success_q <= success_d;
        end
    end

    assign success_o = success_q;

endmodule

// File: rtl/sync_box_arbiter.sv
// Dual-core SyncBox: grants the shared memory port to P0 or P1 with rotating
// priority and a grant watchdog, and resolves atomic reserve/conditional pairs.
module sync_box_arbiter
    import sync_box_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_P0,
    input  logic        req_P1,
    input  logic        mem_complete_P0,
    input  logic        mem_complete_P1,
    input  logic        mw_P0,
    input  logic        mw_P1,
    input  logic        trigger_P0,
    input  logic        trigger_P1,
    input  logic [1:0]  instr_type_P0,
    input  logic [1:0]  instr_type_P1,
    input  logic [31:0] addr_P0,
    input  logic [31:0] addr_P1,
    output logic        pass_P0,
    output logic        pass_P1,
    output logic        success_P0,
    output logic        success_P1,
    output logic [1:0]  owner,
    output logic        timeout_err
);

    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_e          state_q;
    logic            prio_q;
    logic [WD_W-1:0] wd_q;
    logic            pass0_q, pass1_q, tmo_q;
    logic [1:0]      owner_q;

    logic [1:0]       trig, cmpl, wr, hit, lose, clr, succ;
    logic [1:0][1:0]  itype;
    logic [1:0][31:0] addr;
    logic             own_cmpl, wd_fire, same_addr;

    assign trig  = {trigger_P1, trigger_P0};
    assign cmpl  = {mem_complete_P1, mem_complete_P0};
    assign wr    = {mw_P1, mw_P0};
    assign itype = {instr_type_P1, instr_type_P0};
    assign addr  = {addr_P1, addr_P0};

    assign own_cmpl = (state_q == ST_GRANT_P0 && mem_complete_P0)
                   || (state_q == ST_GRANT_P1 && mem_complete_P1);

    // Fires on the last of TIMEOUT held cycles; a completion in that same cycle wins.
    assign wd_fire = (TIMEOUT != 0) && (state_q != ST_IDLE) && !own_cmpl
                     && (wd_q == WD_W'(TIMEOUT - 1));

    assign clr = {wd_fire && state_q == ST_GRANT_P1, wd_fire && state_q == ST_GRANT_P0};

    assign same_addr = (addr_P0[ADDR_W-1:0] == addr_P1[ADDR_W-1:0]);
    assign lose[0]   = hit[0] && hit[1] && same_addr && prio_q;
    assign lose[1]   = hit[0] && hit[1] && same_addr && !prio_q;

    for (genvar g = 0; g < 2; g++) begin : g_rsv
        sync_rsv_unit #(.ADDR_W(ADDR_W)) u_rsv (
            .clk             (clk),
            .reset           (reset),
            .trigger_i       (trig[g]),
            .instr_type_i    (itype[g]),
            .addr_i          (addr[g]),
            .peer_complete_i (cmpl[1-g]),
            .peer_write_i    (wr[1-g]),
            .peer_addr_i     (addr[1-g]),
            .clear_i         (clr[g]),
            .lose_i          (lose[g]),
            .cond_hit_o      (hit[g]),
            .success_o       (succ[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            wd_q    <= '0;
            pass0_q <= 1'b0;
            pass1_q <= 1'b0;
            owner_q <= OWNER_IDLE;
            tmo_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    wd_q <= '0;
                    if (req_P0 && (!req_P1 || !prio_q)) begin
                        state_q <= ST_GRANT_P0;
                        pass0_q <= 1'b1;
                        owner_q <= OWNER_P0;
                    end else if (req_P1) begin
                        state_q <= ST_GRANT_P1;
                        pass1_q <= 1'b1;
                        owner_q <= OWNER_P1;
                    end
                end
                ST_GRANT_P0, ST_GRANT_P1: begin
                    if (own_cmpl || wd_fire) begin
                        state_q <= ST_IDLE;
                        pass0_q <= 1'b0;
                        pass1_q <= 1'b0;
                        owner_q <= OWNER_IDLE;
                        prio_q  <= (state_q == ST_GRANT_P0);
                        if (wd_fire) tmo_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pass_P0     = pass0_q;
    assign pass_P1     = pass1_q;
    assign owner       = owner_q;
    assign timeout_err = tmo_q;
    assign success_P0  = succ[0];
    assign success_P1  = succ[1];

endmodule
